// File: rtl/geofence_pkg.sv
// Shared types and width helpers for the convex-polygon geofence engine.
package geofence_pkg;

    typedef enum logic [1:0] {LOAD, SORT, CHECK, DONE} state_t;

    localparam int unsigned COORD_MAX_W = 16;

    // Differences carry one extra sign bit; a cross product needs one more bit than a product.
    function automatic int unsigned diff_w(input int unsigned coord_w);
        return coord_w + 1;
    endfunction

    function automatic int unsigned cross_w(input int unsigned coord_w);
        return 2 * coord_w + 3;
    endfunction

    typedef struct packed {
        logic [COORD_MAX_W-1:0] x;
        logic [COORD_MAX_W-1:0] y;
    } point_t;

endpackage

// File: rtl/geofence_cross.sv
// Combinational signed cross product of (a - origin) x (b - origin), full precision.
module geofence_cross
    import geofence_pkg::*;
#(
    parameter  int unsigned COORD_W = 10,
    localparam int unsigned CROSS_W = cross_w(COORD_W)
) (
    input  logic [COORD_W-1:0]        origin_x,
    input  logic [COORD_W-1:0]        origin_y,
    input  logic [COORD_W-1:0]        a_x,
    input  logic [COORD_W-1:0]        a_y,
    input  logic [COORD_W-1:0]        b_x,
    input  logic [COORD_W-1:0]        b_y,
    output logic signed [CROSS_W-1:0] result
);

    localparam int unsigned DIFF_W = diff_w(COORD_W);
    localparam int unsigned PROD_W = 2 * DIFF_W;

    logic signed [DIFF_W-1:0] dax, day, dbx, dby;
    logic signed [PROD_W-1:0] prod_xy, prod_yx;

    assign dax = $signed({1'b0, a_x}) - $signed({1'b0, origin_x});
    assign day = $signed({1'b0, a_y}) - $signed({1'b0, origin_y});
    assign dbx = $signed({1'b0, b_x}) - $signed({1'b0, origin_x});
    assign dby = $signed({1'b0, b_y}) - $signed({1'b0, origin_y});

    assign prod_xy = PROD_W'(dax) * PROD_W'(dby);
    assign prod_yx = PROD_W'(day) * PROD_W'(dbx);
    assign result  = CROSS_W'(prod_xy) - CROSS_W'(prod_yx);

endmodule

// File: rtl/geofence_poly.sv
// Convex-polygon geofence: load target + N_VERTS vertices, angular bubble sort, edge test.
// Define GEOFENCE_EDGE_INSIDE_EN to report points on an edge or vertex as inside.
module geofence_poly
    import geofence_pkg::*;
#(
    parameter int unsigned N_VERTS = 6,
    parameter int unsigned COORD_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    output logic               out_valid,
    output logic               is_inside,
    output logic               busy
);

    localparam int unsigned CROSS_W = cross_w(COORD_W);
    localparam int unsigned BEAT_W  = $clog2(N_VERTS + 1);
    localparam int unsigned IDX_W   = $clog2(N_VERTS);
    localparam logic signed [CROSS_W-1:0] ZERO = '0;

    state_t             state;
    logic [BEAT_W-1:0]  beat;
    logic [IDX_W-1:0]   sort_i, sort_pass, chk_k;
    logic               fail;
    logic [COORD_W-1:0] tx, ty;
    logic [COORD_W-1:0] vx [N_VERTS];
    logic [COORD_W-1:0] vy [N_VERTS];

    logic [IDX_W-1:0]          sort_j, chk_n;
    logic signed [CROSS_W-1:0] sort_c, chk_c;
    logic                      sort_swap, edge_bad;

    assign sort_j = sort_i + IDX_W'(1);
    assign chk_n  = (chk_k == IDX_W'(N_VERTS - 1)) ? '0 : chk_k + IDX_W'(1);

    geofence_cross #(.COORD_W(COORD_W)) u_sort_cross (
        .origin_x (vx[0]),      .origin_y (vy[0]),
        .a_x      (vx[sort_i]), .a_y      (vy[sort_i]),
        .b_x      (vx[sort_j]), .b_y      (vy[sort_j]),
        .result   (sort_c)
    );

    geofence_cross #(.COORD_W(COORD_W)) u_chk_cross (
        .origin_x (vx[chk_k]), .origin_y (vy[chk_k]),
        .a_x      (vx[chk_n]), .a_y      (vy[chk_n]),
        .b_x      (tx),        .b_y      (ty),
        .result   (chk_c)
    );

    // Clockwise pairs are swapped so the array ends up counter-clockwise around v[0].
    assign sort_swap = (sort_c < ZERO);

`ifdef GEOFENCE_EDGE_INSIDE_EN
    assign edge_bad = (chk_c < ZERO);
`else
    assign edge_bad = (chk_c < ZERO) || (chk_c == ZERO);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD;
            beat      <= '0;
            sort_i    <= '0;
            sort_pass <= '0;
            chk_k     <= '0;
            fail      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            is_inside <= 1'b0;
            busy      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        busy <= 1'b1;
                        if (beat == '0) begin
                            tx <= in_x;
                            ty <= in_y;
                        end else begin
                            vx[IDX_W'(beat - BEAT_W'(1))] <= in_x;
                            vy[IDX_W'(beat - BEAT_W'(1))] <= in_y;
                        end
                        if (beat == BEAT_W'(N_VERTS)) begin
                            beat      <= '0;
                            in_ready  <= 1'b0;
                            sort_i    <= IDX_W'(1);
                            sort_pass <= '0;
                            state     <= SORT;
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                SORT: begin
                    if (sort_swap) begin
                        vx[sort_i] <= vx[sort_j];
                        vy[sort_i] <= vy[sort_j];
                        vx[sort_j] <= vx[sort_i];
                        vy[sort_j] <= vy[sort_i];
                    end
                    if (sort_i == IDX_W'(N_VERTS - 2)) begin
                        sort_i <= IDX_W'(1);
                        if (sort_pass == IDX_W'(N_VERTS - 3)) begin
                            chk_k <= '0;
                            fail  <= 1'b0;
                            state <= CHECK;
                        end else begin
                            sort_pass <= sort_pass + IDX_W'(1);
                        end
                    end else begin
                        sort_i <= sort_j;
                    end
                end
                CHECK: begin
                    if (edge_bad) begin
                        fail <= 1'b1;
                    end
                    if (chk_k == IDX_W'(N_VERTS - 1)) begin
                        out_valid <= 1'b1;
                        is_inside <= ~(fail | edge_bad);
                        state     <= DONE;
                    end else begin
                        chk_k <= chk_n;
                    end
                end
                DONE: begin
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_geofence_poly.sv
// Self-checking bench for geofence_poly: directed frames plus random convex polygons vs a hull model.
module tb_geofence_poly;

`ifdef GEOFENCE_EDGE_INSIDE_EN
    localparam bit EDGE_IN = 1'b1;
`else
    localparam bit EDGE_IN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [2:0] vld;
    logic [9:0] drv_x, drv_y;
    wire  [2:0] rdy, ov, ins, bsy;

    int checks, errors;
    int fx [16];
    int fy [16];
    int ftx, fty;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    geofence_poly #(.N_VERTS(4), .COORD_W(10)) u_n4 (
        .clk(clk), .reset(reset), .in_valid(vld[0]), .in_ready(rdy[0]),
        .in_x(drv_x), .in_y(drv_y), .out_valid(ov[0]), .is_inside(ins[0]), .busy(bsy[0])
    );
    geofence_poly #(.N_VERTS(6), .COORD_W(10)) u_n6 (
        .clk(clk), .reset(reset), .in_valid(vld[1]), .in_ready(rdy[1]),
        .in_x(drv_x), .in_y(drv_y), .out_valid(ov[1]), .is_inside(ins[1]), .busy(bsy[1])
    );
    geofence_poly #(.N_VERTS(3), .COORD_W(4)) u_n3 (
        .clk(clk), .reset(reset), .in_valid(vld[2]), .in_ready(rdy[2]),
        .in_x(drv_x[3:0]), .in_y(drv_y[3:0]), .out_valid(ov[2]), .is_inside(ins[2]), .busy(bsy[2])
    );

    function automatic int nv(input int sel);
        return (sel == 0) ? 4 : (sel == 1) ? 6 : 3;
    endfunction

    function automatic longint cr(input int ox, oy, ax, ay, bx, by);
        return longint'(ax - ox) * longint'(by - oy) - longint'(ay - oy) * longint'(bx - ox);
    endfunction

    // Hull edges are vertex pairs with every other vertex strictly to the left; order-independent.
    function automatic bit ref_inside(input int n);
        bit ok, hull;
        longint c;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                if (i != j) begin
                    hull = 1'b1;
                    for (int k = 0; k < n; k++)
                        if (k != i && k != j && cr(fx[i], fy[i], fx[j], fy[j], fx[k], fy[k]) <= 0)
                            hull = 1'b0;
                    if (hull) begin
                        c = cr(fx[i], fy[i], fx[j], fy[j], ftx, fty);
                        if (c < 0 || (c == 0 && !EDGE_IN)) ok = 1'b0;
                    end
                end
            end
        end
        return ok;
    endfunction

    task automatic send_beats(input int sel, input bit gaps, output bit ok);
        bit acc;
        int guard;
        ok = 1'b1;
        for (int b = 0; b <= nv(sel); b++) begin
            if (gaps && b > 0) begin
                vld = '0;
                repeat (2) begin @(posedge clk); #1; end
            end
            if (b == 0) begin
                drv_x = 10'(ftx); drv_y = 10'(fty);
            end else begin
                drv_x = 10'(fx[b-1]); drv_y = 10'(fy[b-1]);
            end
            vld = '0;
            vld[sel] = 1'b1;
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 64) begin
                acc = rdy[sel];
                @(posedge clk); #1;
                guard++;
            end
            if (!acc) begin
                ok = 1'b0;
                break;
            end
        end
        vld = '0;
    endtask

    task automatic run_frame(input int sel, input bit gaps, input bit exp_in, input string name);
        int n, exp_lat, lat;
        bit ok, hs_bad;
        n = nv(sel);
        exp_lat = 1 + (n - 2) * (n - 2) + n;
        send_beats(sel, gaps, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: beats_taken=%b required=1", name, ok);
            return;
        end
        lat = 1;
        hs_bad = 1'b0;
        while (ov[sel] !== 1'b1 && lat < 400) begin
            if (rdy[sel] !== 1'b0 || bsy[sel] !== 1'b1) hs_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (rdy[sel] !== 1'b0 || bsy[sel] !== 1'b1) hs_bad = 1'b1;
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got=%0d required=%0d", name, lat, exp_lat);
        end
        checks++;
        if (hs_bad !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_busy: in_ready/busy wrong while processing, got=%b required=0", name, hs_bad);
        end
        checks++;
        if (ins[sel] !== exp_in) begin
            errors++;
            $display("FAIL %s is_inside: got=%b required=%b", name, ins[sel], exp_in);
        end
    endtask

    task automatic post_check(input int sel, input string name);
        @(posedge clk); #1;
        checks++;
        if ({ov[sel], rdy[sel], bsy[sel]} !== 3'b010) begin
            errors++;
            $display("FAIL %s after_done: {out_valid,in_ready,busy}=%b required=010", name,
                     {ov[sel], rdy[sel], bsy[sel]});
        end
    endtask

    task automatic load_square();
        fx[0] = 10; fy[0] = 10; fx[1] = 0;  fy[1] = 0;
        fx[2] = 0;  fy[2] = 10; fx[3] = 10; fy[3] = 0;
    endtask

    task automatic load_hexagon();
        fx[0] = 1023; fy[0] = 512;  fx[1] = 256; fy[1] = 0;
        fx[2] = 0;    fy[2] = 512;  fx[3] = 768; fy[3] = 1023;
        fx[4] = 256;  fy[4] = 1023; fx[5] = 768; fy[5] = 0;
    endtask

    task automatic load_triangle();
        fx[0] = 0; fy[0] = 0; fx[1] = 15; fy[1] = 0; fx[2] = 0; fy[2] = 15;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        vld = '0;
        drv_x = '0; drv_y = '0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({ov[s], rdy[s], bsy[s]} !== 3'b010) begin
                errors++;
                $display("FAIL reset_s%0d: {out_valid,in_ready,busy}=%b required=010", s, {ov[s], rdy[s], bsy[s]});
            end
        end
    endtask

    task automatic test_square();
        load_square();
        ftx = 5;  fty = 5; run_frame(0, 1'b0, 1'b1, "sq_center"); post_check(0, "sq_center");
        ftx = 15; fty = 5; run_frame(0, 1'b0, 1'b0, "sq_outside"); post_check(0, "sq_outside");
        ftx = 10; fty = 5; run_frame(0, 1'b0, EDGE_IN, "sq_edge");  post_check(0, "sq_edge");
    endtask

    task automatic test_hexagon();
        load_hexagon();
        ftx = 512;  fty = 512;  run_frame(1, 1'b0, 1'b1, "hex_center"); post_check(1, "hex_center");
        ftx = 1023; fty = 1023; run_frame(1, 1'b0, 1'b0, "hex_corner"); post_check(1, "hex_corner");
    endtask

    task automatic test_backpressure();
        load_hexagon();
        ftx = 512; fty = 512; run_frame(1, 1'b1, 1'b1, "bp_center"); post_check(1, "bp_center");
        ftx = 100; fty = 100; run_frame(1, 1'b1, 1'b0, "bp_out");    post_check(1, "bp_out");
    endtask

    task automatic test_reset_mid_sort();
        bit ok, seen;
        load_hexagon();
        ftx = 1023; fty = 1023;
        send_beats(1, 1'b0, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL rst_sort accept: beats_taken=%b required=1", ok);
        end
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({ov[1], rdy[1], bsy[1]} !== 3'b010) begin
            errors++;
            $display("FAIL rst_sort state: {out_valid,in_ready,busy}=%b required=010", {ov[1], rdy[1], bsy[1]});
        end
        seen = 1'b0;
        repeat (40) begin
            if (ov[1] === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_sort strobe: out_valid_seen=%b required=0", seen);
        end
        ftx = 512; fty = 512; run_frame(1, 1'b0, 1'b1, "rst_sort_fresh"); post_check(1, "rst_sort_fresh");
    endtask

    task automatic test_triangle();
        load_triangle();
        ftx = 3;  fty = 3;  run_frame(2, 1'b0, 1'b1, "tri_in");     post_check(2, "tri_in");
        ftx = 15; fty = 15; run_frame(2, 1'b0, 1'b0, "tri_out");    post_check(2, "tri_out");
        ftx = 0;  fty = 0;  run_frame(2, 1'b0, EDGE_IN, "tri_vtx"); post_check(2, "tri_vtx");
    endtask

    task automatic test_back_to_back();
        load_triangle();
        ftx = 3;  fty = 3;  run_frame(2, 1'b0, 1'b1, "b2b_first");
        ftx = 12; fty = 12; run_frame(2, 1'b0, 1'b0, "b2b_second");
        post_check(2, "b2b_second");
    endtask

    task automatic gen_polygon(input int sel);
        int n, a, mode, j, t;
        bit [31:0] taken;
        n = nv(sel);
        if (sel == 2) begin
            do begin
                for (int i = 0; i < 3; i++) begin
                    fx[i] = $urandom_range(0, 15);
                    fy[i] = $urandom_range(0, 15);
                end
            end while (cr(fx[0], fy[0], fx[1], fy[1], fx[2], fy[2]) == 0);
        end else begin
            // Points on a parabola are strictly convex; swapping/mirroring keeps them so.
            taken = '0;
            mode = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) begin
                do a = $urandom_range(0, 31); while (taken[a]);
                taken[a] = 1'b1;
                fx[i] = 32 * a;
                fy[i] = a * a;
                if (mode % 2 == 1) begin
                    t = fx[i]; fx[i] = fy[i]; fy[i] = t;
                end
                if (mode >= 2) fy[i] = 1023 - fy[i];
            end
            for (int i = n - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = fx[i]; fx[i] = fx[j]; fx[j] = t;
                t = fy[i]; fy[i] = fy[j]; fy[j] = t;
            end
        end
    endtask

    task automatic gen_target(input int sel);
        int n, maxc, i, j, sx, sy;
        n = nv(sel);
        maxc = (sel == 2) ? 15 : 1023;
        i = $urandom_range(0, n - 1);
        j = $urandom_range(0, n - 1);
        case ($urandom_range(0, 3))
            0: begin ftx = $urandom_range(0, maxc); fty = $urandom_range(0, maxc); end
            1: begin ftx = fx[i]; fty = fy[i]; end
            2: begin ftx = (fx[i] + fx[j]) / 2; fty = (fy[i] + fy[j]) / 2; end
            default: begin
                sx = 0; sy = 0;
                for (int k = 0; k < n; k++) begin sx += fx[k]; sy += fy[k]; end
                ftx = sx / n; fty = sy / n;
            end
        endcase
    endtask

    task automatic test_random(input int sel, input int iters);
        bit exp_in;
        for (int it = 0; it < iters; it++) begin
            gen_polygon(sel);
            gen_target(sel);
            exp_in = ref_inside(nv(sel));
            run_frame(sel, 1'($urandom_range(0, 1)), exp_in, $sformatf("rand_s%0d_%0d", sel, it));
            post_check(sel, $sformatf("rand_s%0d_%0d", sel, it));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_square();
        test_hexagon();
        test_backpressure();
        test_reset_mid_sort();
        test_triangle();
        test_back_to_back();
        test_random(0, 12);
        test_random(1, 12);
        test_random(2, 12);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/geofence_poly.md
Name: geofence_poly

Overview:
- Parametrised successor of the fixed six-receiver geofence engine.
- Accepts one target point, then N_VERTS unordered vertices of a convex polygon.
- Orders the vertices angularly around vertex 0 with cross products, then tests whether the target lies inside.
- Sits behind the coordinate stream front end; reports a single-cycle result pulse per frame.

Parameters:
- N_VERTS, 6, number of polygon vertices (legal 3..16).
- COORD_W, 10, unsigned coordinate width (legal 4..16).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  coordinate beat valid
- in_ready  out  1  block accepts beats; high only in LOAD
- in_x  in  COORD_W  unsigned X
- in_y  in  COORD_W  unsigned Y
- out_valid  out  1  one-cycle result strobe
- is_inside  out  1  result, meaningful only while out_valid=1
- busy  out  1  high from first accepted beat until the out_valid cycle inclusive

Behaviour:
- Reset values: in_ready=1, out_valid=0, is_inside=0, busy=0. State=LOAD, beat counter=0.
- Reset asserted at any point aborts the frame; no out_valid is produced for it.
- Arithmetic:
  - Differences are sign-extended to COORD_W+1 bits.
  - Products are 2*COORD_W+2 bits.
  - cross(a,b) = a.x*b.y - a.y*b.x, held in 2*COORD_W+3 signed bits.
  - No truncation is permitted.
- LOAD:
  - A beat transfers when in_valid & in_ready.
  - Beat 0 is the target; beats 1..N_VERTS are v[0]..v[N_VERTS-1].
  - Gaps in in_valid are allowed.
  - The cycle after the last beat transfers: in_ready=0, go to SORT.
- SORT:
  - Bubble sort of v[1..N_VERTS-1], one comparison per cycle.
  - Exactly (N_VERTS-2)^2 cycles: N_VERTS-2 passes, indices i=1..N_VERTS-2 per pass.
  - Swap v[i], v[i+1] when cross(v[i]-v[0], v[i+1]-v[0]) < 0; the result is counter-clockwise order.
  - When N_VERTS=3 the sort is 1 pass of 1 cycle, not 0.
- CHECK:
  - Exactly N_VERTS cycles, edge k = v[k] to v[(k+1) mod N_VERTS], where index N_VERTS wraps to 0.
  - c_k = cross(v[k+1]-v[k], T-v[k]).
  - An edge fails if c_k < 0, or if c_k == 0 (see optional feature).
  - A sticky fail flag is cleared on entry to CHECK.
  - There is no early exit.
- DONE:
  - One cycle: out_valid=1, is_inside = ~fail, busy=1.
  - Next cycle: out_valid=0, busy=0, in_ready=1, state=LOAD.
- Latency: from the last beat transfer to out_valid = 1 + S + N_VERTS cycles, where S is the SORT cycle count above. For N_VERTS=6 this is 23 cycles.
- Vertex inputs are required to be distinct and strictly convex. For degenerate input, is_inside is don't-care, but timing must be unchanged.
- is_inside holds its last value when out_valid=0; benches must not check it then.

Optional Feature:
- Macro: GEOFENCE_EDGE_INSIDE_EN.
- Defined: c_k == 0 passes, so points on an edge or vertex report inside.
- Undefined: c_k == 0 fails (strict interior), matching the previous generation.
- Timing is identical in both builds.

Decomposition:
- Package geofence_pkg holds:
  - the state enum (LOAD, SORT, CHECK, DONE);
  - localparam width helpers DIFF_W = COORD_W+1 and CROSS_W = 2*COORD_W+3, expressed as functions of COORD_W;
  - the point struct {x,y}.
- Sub-module geofence_cross: combinational, parametrised by COORD_W. Inputs are origin, a, b; output is signed cross(a-origin, b-origin). Two instances: one for SORT, one for CHECK.

Test Plan:
- N=4, W=10, target (5,5), vertices (10,10),(0,0),(0,10),(10,0) -> out_valid exactly 1+4+4=9 cycles after the last beat, is_inside=1.
- Same vertices, target (15,5) -> is_inside=0. Target (10,5) -> 0 without macro, 1 with GEOFENCE_EDGE_INSIDE_EN.
- N=6, W=10, target (512,512), hexagon (1023,512),(256,0),(0,512),(768,1023),(256,1023),(768,0) shuffled -> is_inside=1 at 23 cycles. Target (1023,1023) -> 0. Confirms full-width products are not truncated.
- Backpressure: in_valid toggled 1,0,0,1,... across all 7 beats -> the result is identical to contiguous input; in_ready=0 from the post-LOAD cycle until the cycle after out_valid.
- reset pulsed in the 3rd SORT cycle -> no out_valid; in_ready=1 next cycle; a fresh frame then produces the correct result.
- N=3, W=4, triangle (0,0),(15,0),(0,15), target (3,3) -> is_inside=1 after 1+1+3=5 cycles. Back-to-back frames with no idle give two distinct strobes.
